// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: conditions ps2c/ps2d, decodes 11-bit frames and
// buffers validated scancodes in a small first-word fall-through FIFO.
module ps2_keyboard_rx #(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 100000,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       ps2c,
  input  logic       ps2d,
  input  logic       rd,
  input  logic       clr_ovf,
  output logic [7:0] data,
  output logic       valid,
  output logic       overflow,
  output logic       frame_err,
  output logic       irq
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned AW = $clog2(FILTER_LEN + 3);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic          r_c_s1, r_c_s2, r_d_s1, r_d_s2;
  logic          r_filt, r_filt_q;
  logic [FW-1:0] r_fcnt;
  logic          r_armed;
  logic [AW-1:0] r_arm_cnt;
  state_t        r_state;
  logic [7:0]    r_shift;
  logic [2:0]    r_bitcnt;
  logic          r_par;
  logic [TW-1:0] r_tcnt;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_cnt;

  logic          w_fall, w_good, w_push;
  logic          w_pop, w_wr, w_drop;
  logic [CW-1:0] w_cnt_n;
  logic [PW-1:0] w_rptr_n, w_wptr_n;
  logic [7:0]    w_head_n;

  // Two-flop synchronizers, preset to the idle-high bus level
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_c_s1 <= 1'b1;
      r_c_s2 <= 1'b1;
      r_d_s1 <= 1'b1;
      r_d_s2 <= 1'b1;
    end else begin
      r_c_s1 <= ps2c;
      r_c_s2 <= r_c_s1;
      r_d_s1 <= ps2d;
      r_d_s2 <= r_d_s1;
    end
  end

  // Glitch filter on ps2c, plus an arm gate so a reset mid-frame cannot
  // turn a still-low ps2c into a bogus start bit
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_filt    <= 1'b1;
      r_filt_q  <= 1'b1;
      r_fcnt    <= '0;
      r_armed   <= 1'b0;
      r_arm_cnt <= '0;
    end else begin
      r_filt_q <= r_filt;
      if (r_c_s2 == r_filt) begin
        r_fcnt <= '0;
      end else if (r_fcnt == FW'(FILTER_LEN - 1)) begin
        r_filt <= r_c_s2;
        r_fcnt <= '0;
      end else begin
        r_fcnt <= r_fcnt + FW'(1);
      end
      if (!r_armed) begin
        if (!r_c_s2)
          r_arm_cnt <= '0;
        else if (r_arm_cnt == AW'(FILTER_LEN + 1))
          r_armed <= 1'b1;
        else
          r_arm_cnt <= r_arm_cnt + AW'(1);
      end
    end
  end

  assign w_fall = r_armed & r_filt_q & ~r_filt;
  assign w_good = r_d_s2 & (^{r_shift, r_par});
  assign w_push = (r_state == S_STOP) & w_fall & w_good;

  // Frame decoder with inter-edge timeout
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_bitcnt  <= '0;
      r_par     <= 1'b0;
      r_tcnt    <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (r_state == S_IDLE || w_fall) begin
        r_tcnt <= '0;
      end else if (r_tcnt == TW'(TIMEOUT_CYC - 1)) begin
        r_tcnt    <= '0;
        r_state   <= S_IDLE;
        frame_err <= 1'b1;
      end else begin
        r_tcnt <= r_tcnt + TW'(1);
      end
      if (w_fall) begin
        case (r_state)
          S_IDLE: begin
            if (!r_d_s2) begin
              r_state  <= S_DATA;
              r_shift  <= '0;
              r_bitcnt <= '0;
            end
          end
          S_DATA: begin
            r_shift  <= {r_d_s2, r_shift[7:1]};
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) r_state <= S_PARITY;
          end
          S_PARITY: begin
            r_par   <= r_d_s2;
            r_state <= S_STOP;
          end
          default: begin
            r_state <= S_IDLE;
            if (!w_good) frame_err <= 1'b1;
          end
        endcase
      end
    end
  end

  // FIFO next-state: pop before push so a full FIFO can still accept on a read
  always_comb begin
    w_pop    = rd & (r_cnt != '0);
    w_wr     = w_push & ((r_cnt != CW'(FIFO_DEPTH)) | w_pop);
    w_drop   = w_push & ~w_wr;
    w_cnt_n  = r_cnt + CW'(w_wr) - CW'(w_pop);
    w_rptr_n = w_pop ? r_rptr + PW'(1) : r_rptr;
    w_wptr_n = w_wr ? r_wptr + PW'(1) : r_wptr;
    w_head_n = (w_wr && r_wptr == w_rptr_n) ? r_shift : r_mem[w_rptr_n];
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) r_mem[i] <= '0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_cnt    <= '0;
      data     <= '0;
      valid    <= 1'b0;
      overflow <= 1'b0;
      irq      <= 1'b0;
    end else begin
      if (w_wr) r_mem[r_wptr] <= r_shift;
      r_wptr <= w_wptr_n;
      r_rptr <= w_rptr_n;
      r_cnt  <= w_cnt_n;
      valid  <= (w_cnt_n != '0);
      data   <= (w_cnt_n != '0) ? w_head_n : 8'h00;
      irq    <= w_wr;
      if (w_drop)
        overflow <= 1'b1;
      else if (clr_ovf)
        overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed and randomized PS/2 frames checked against a queue-based scancode model.
module tb_ps2_keyboard_rx;

  localparam int FL    = 8;
  localparam int TOC   = 1000;
  localparam int DEPTH = 4;
  localparam int H     = 20;

  logic       clk = 1'b0;
  logic       nreset, ps2c, ps2d, rd, clr_ovf;
  logic [7:0] data;
  logic       valid, overflow, frame_err, irq;

  int total = 0;
  int bad   = 0;
  int irq_cnt = 0, err_cnt = 0, both_cnt = 0;
  int exp_irq = 0, exp_err = 0;
  bit exp_ovf = 1'b0;
  logic [7:0] q[$];

  ps2_keyboard_rx #(.FILTER_LEN(FL), .TIMEOUT_CYC(TOC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .nreset(nreset), .ps2c(ps2c), .ps2d(ps2d), .rd(rd),
    .clr_ovf(clr_ovf), .data(data), .valid(valid), .overflow(overflow),
    .frame_err(frame_err), .irq(irq)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (irq) irq_cnt++;
    if (frame_err) err_cnt++;
    if (irq && frame_err) both_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [7:0] hd;
    hd = (q.size() != 0) ? q[0] : 8'h00;
    check($sformatf("%s.valid", tag), 32'(valid), 32'(q.size() != 0));
    check($sformatf("%s.data", tag), 32'(data), 32'(hd));
    check($sformatf("%s.overflow", tag), 32'(overflow), 32'(exp_ovf));
    check($sformatf("%s.irqs", tag), 32'(irq_cnt), 32'(exp_irq));
    check($sformatf("%s.errs", tag), 32'(err_cnt), 32'(exp_err));
  endtask

  task automatic send_bit(input bit b, input bit glitch);
    ps2d = b;
    if (glitch) begin
      cyc(5);
      ps2c = 1'b0;
      cyc(FL - 1);
      ps2c = 1'b1;
      cyc(H - 5 - (FL - 1));
    end else begin
      cyc(H);
    end
    ps2c = 1'b0;
    cyc(H);
    ps2c = 1'b1;
  endtask

  // kind: 0 good, 1 parity flipped, 2 stop bit low; nbits < 11 sends a truncated frame
  task automatic send_frame(input logic [7:0] b, input int kind, input bit glitch, input int nbits);
    bit bits[11];
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = b[i];
    bits[9]  = (~^b) ^ (kind == 1);
    bits[10] = (kind != 2);
    for (int i = 0; i < nbits; i++) send_bit(bits[i], glitch);
    ps2d = 1'b1;
    cyc(H);
  endtask

  task automatic model_frame(input logic [7:0] b, input int kind);
    if (kind != 0) exp_err++;
    else if (q.size() < DEPTH) begin
      q.push_back(b);
      exp_irq++;
    end else exp_ovf = 1'b1;
  endtask

  task automatic frame(input string tag, input logic [7:0] b, input int kind, input bit glitch);
    send_frame(b, kind, glitch, 11);
    model_frame(b, kind);
    check_all(tag);
  endtask

  task automatic do_pop(input string tag);
    logic [7:0] hd;
    hd = (q.size() != 0) ? q[0] : 8'h00;
    check($sformatf("%s.head", tag), 32'(data), 32'(hd));
    rd = 1'b1;
    cyc(1);
    rd = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
    check_all($sformatf("%s.after", tag));
  endtask

  task automatic do_clr(input string tag);
    clr_ovf = 1'b1;
    cyc(1);
    clr_ovf = 1'b0;
    exp_ovf = 1'b0;
    check_all(tag);
  endtask

  initial begin
    logic [7:0] b;
    int kind;
    nreset = 1'b0; ps2c = 1'b1; ps2d = 1'b1; rd = 1'b0; clr_ovf = 1'b0;
    cyc(3);
    check_all("reset");
    nreset = 1'b1;
    cyc(20);

    frame("t1_1c", 8'h1C, 0, 1'b0);
    do_pop("t1_pop");
    frame("t2_badpar", 8'h1C, 1, 1'b0);
    frame("t2_badstop", 8'h3C, 2, 1'b0);

    for (int i = 1; i <= 5; i++) frame($sformatf("t3_f%0d", i), 8'(i), 0, 1'b0);
    for (int i = 0; i < 4; i++) do_pop($sformatf("t3_pop%0d", i));
    do_pop("t3_pop_empty");
    do_clr("t3_clr");

    send_frame(8'h77, 0, 1'b0, 4);
    cyc(TOC + 200);
    exp_err++;
    check_all("t4_timeout");
    frame("t4_f0", 8'hF0, 0, 1'b0);
    do_pop("t4_pop");

    frame("t5_glitch", 8'hAA, 0, 1'b1);
    do_pop("t5_pop");

    for (int n = 0; n < 20; n++) begin
      b = 8'($urandom);
      case ($urandom_range(0, 7))
        0:       kind = 1;
        1:       kind = 2;
        default: kind = 0;
      endcase
      frame($sformatf("rnd%0d", n), b, kind, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) do_pop($sformatf("rnd%0d_pop", n));
      if (exp_ovf && $urandom_range(0, 1) == 1) do_clr($sformatf("rnd%0d_clr", n));
    end

    while (q.size() != 0) do_pop("drain");
    do_clr("drain_clr");
    frame("t6_a", 8'h12, 0, 1'b0);
    frame("t6_b", 8'h34, 0, 1'b0);
    send_frame(8'h99, 0, 1'b0, 3);
    nreset = 1'b0;
    q.delete();
    exp_ovf = 1'b0;
    cyc(1);
    check_all("t6_in_reset");
    cyc(2);
    nreset = 1'b1;
    cyc(1);
    check_all("t6_after_reset");
    cyc(30);
    frame("t6_5a", 8'h5A, 0, 1'b0);
    do_pop("t6_pop");

    check("never_both", 32'(both_cnt), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
